// File: rtl/dp_ram_sc_if.sv
// dp_ram_sc_if: bus bundle for the dual-port RAM.
//   Port A / port B request signals: *_en, *_we (per byte lane), *_addr, *_din
//   Port A / port B response signals: *_dout, *_valid
//   Status: busy (reset or clear running), collision (cross-port conflict pulse)
// The master modport drives requests; the slave modport (the RAM) drives
// responses and status.
interface dp_ram_sc_if #(
    parameter int DATA = 16,
    parameter int ADDR = 10,
    parameter int LANE = 8
);
    localparam int NL = DATA / LANE;

    logic            busy;
    logic            collision;

    logic            a_en;
    logic [NL-1:0]   a_we;
    logic [ADDR-1:0] a_addr;
    logic [DATA-1:0] a_din;
    logic [DATA-1:0] a_dout;
    logic            a_valid;

    logic            b_en;
    logic [NL-1:0]   b_we;
    logic [ADDR-1:0] b_addr;
    logic [DATA-1:0] b_din;
    logic [DATA-1:0] b_dout;
    logic            b_valid;

    modport master (
        output a_en, a_we, a_addr, a_din,
        output b_en, b_we, b_addr, b_din,
        input  a_dout, a_valid, b_dout, b_valid,
        input  busy, collision
    );

    modport slave (
        input  a_en, a_we, a_addr, a_din,
        input  b_en, b_we, b_addr, b_din,
        output a_dout, a_valid, b_dout, b_valid,
        output busy, collision
    );
endinterface

// File: rtl/dp_ram_sc.sv
// dp_ram_sc: single-clock true dual-port RAM with byte-lane write enables,
// optional output register, selectable same-port read-during-write behaviour,
// a post-reset clear engine and cross-port collision detection.
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : dp_ram_sc_if.slave (port A/B requests and responses, busy, collision)
// Parameters: DATA word width, ADDR address width, LANE byte-lane width,
// MODE 0 write-first / 1 read-first / 2 no-change, PIPE extra output stage,
// CLEAR_VAL value written to every word after reset.
module dp_ram_sc #(
    parameter int              DATA      = 16,
    parameter int              ADDR      = 10,
    parameter int              LANE      = 8,
    parameter int              MODE      = 0,
    parameter int              PIPE      = 0,
    parameter logic [DATA-1:0] CLEAR_VAL = '0
) (
    input logic         clk,
    input logic         rst,
    dp_ram_sc_if.slave  bus
);
    localparam int NL    = DATA / LANE;
    localparam int DEPTH = 2 ** ADDR;

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_IDLE} state_t;

    state_t          state_q;
    logic [ADDR-1:0] clr_cnt_q;
    logic            busy_q;
    logic            coll_q;

    logic [DATA-1:0] mem [DEPTH];

    // Per-port views so both ports share one generate body.
    logic [1:0]      acc;
    logic [NL-1:0]   we_p   [2];
    logic [ADDR-1:0] addr_p [2];
    logic [DATA-1:0] din_p  [2];
    logic [DATA-1:0] old_p  [2];
    logic [DATA-1:0] dout_p [2];
    logic            valid_p[2];

    assign we_p[0]   = bus.a_we;
    assign we_p[1]   = bus.b_we;
    assign addr_p[0] = bus.a_addr;
    assign addr_p[1] = bus.b_addr;
    assign din_p[0]  = bus.a_din;
    assign din_p[1]  = bus.b_din;

    // busy_q already covers reset after the first edge; rst is folded in so
    // nothing is accepted on the very first reset edge either.
    assign acc[0] = bus.a_en && !busy_q && !rst;
    assign acc[1] = bus.b_en && !busy_q && !rst;

    // Old contents, sampled before this edge's writes: this is what gives
    // read-first behaviour across ports.
    assign old_p[0] = mem[addr_p[0]];
    assign old_p[1] = mem[addr_p[1]];

    // The clear engine borrows port A's write path; ports are idle while busy.
    logic            wa_en;
    logic [NL-1:0]   wa_we;
    logic [ADDR-1:0] wa_addr;
    logic [DATA-1:0] wa_data;

    always_comb begin
        wa_en   = acc[0];
        wa_we   = we_p[0];
        wa_addr = addr_p[0];
        wa_data = din_p[0];
        if (state_q == ST_CLEAR) begin
            wa_en   = 1'b1;
            wa_we   = '1;
            wa_addr = clr_cnt_q;
            wa_data = CLEAR_VAL;
        end
    end

    // Port B's write is issued after port A's, so B wins shared lanes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (wa_en && wa_we[i])
                mem[wa_addr][i*LANE +: LANE] <= wa_data[i*LANE +: LANE];
            if (acc[1] && we_p[1][i])
                mem[addr_p[1]][i*LANE +: LANE] <= din_p[1][i*LANE +: LANE];
        end
    end

    // Clear engine: RESET -> CLEAR (one word per cycle) -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_RESET: state_q <= ST_CLEAR;
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR'(1);
                    if (clr_cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE:  state_q <= ST_IDLE;
                default:  state_q <= ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            coll_q <= 1'b0;
        else
            coll_q <= acc[0] && acc[1] && (addr_p[0] == addr_p[1]) &&
                      ((|we_p[0]) || (|we_p[1]));
    end

    genvar gi, gl;
    for (gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA-1:0] merged;
        logic            rd_ok;
        logic [DATA-1:0] rd_word;
        logic [DATA-1:0] s1_q;
        logic            s1_v_q;

        for (gl = 0; gl < NL; gl++) begin : g_lane
            assign merged[gl*LANE +: LANE] = we_p[gi][gl] ? din_p[gi][gl*LANE +: LANE]
                                                          : old_p[gi][gl*LANE +: LANE];
        end

        // No-change mode suppresses the response of a writing access;
        // for pure reads merged equals old, so write-first is harmless there.
        assign rd_ok   = acc[gi] && !((MODE == 2) && (|we_p[gi]));
        assign rd_word = (MODE == 0) ? merged : old_p[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q   <= '0;
                s1_v_q <= 1'b0;
            end else begin
                s1_v_q <= rd_ok;
                if (rd_ok)
                    s1_q <= rd_word;
            end
        end

        if (PIPE != 0) begin : g_pipe
            logic [DATA-1:0] s2_q;
            logic            s2_v_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_q   <= '0;
                    s2_v_q <= 1'b0;
                end else begin
                    s2_q   <= s1_q;
                    s2_v_q <= s1_v_q;
                end
            end
            assign dout_p[gi]  = s2_q;
            assign valid_p[gi] = s2_v_q;
        end else begin : g_nopipe
            assign dout_p[gi]  = s1_q;
            assign valid_p[gi] = s1_v_q;
        end
    end

    assign bus.a_dout    = dout_p[0];
    assign bus.a_valid   = valid_p[0];
    assign bus.b_dout    = dout_p[1];
    assign bus.b_valid   = valid_p[1];
    assign bus.busy      = busy_q;
    assign bus.collision = coll_q;
endmodule

// File: tb/tb_dp_ram_sc.sv
// Testbench for dp_ram_sc. Four instances share one stimulus stream:
// cfg0 MODE0/PIPE0, cfg1 MODE1/PIPE0, cfg2 MODE2/PIPE0, cfg3 MODE0/PIPE1.
// A behavioural model (plain word array plus per-config output delay line)
// is checked against every instance on every cycle.
module tb_dp_ram_sc;
    localparam int DATA = 16, ADDR = 4, LANE = 8, NL = 2, DEPTH = 16, NCFG = 4;
    localparam logic [15:0] CV = 16'hA5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_en = 0, b_en = 0;
    logic [1:0]  a_we = 0, b_we = 0;
    logic [3:0]  a_addr = 0, b_addr = 0;
    logic [15:0] a_din = 0, b_din = 0;

    logic [15:0] dut_dout [NCFG][2];
    logic        dut_valid[NCFG][2];
    logic        dut_busy [NCFG];
    logic        dut_coll [NCFG];

    int n_checks = 0;
    int n_errors = 0;

    genvar gi;
    for (gi = 0; gi < NCFG; gi++) begin : g_cfg
        dp_ram_sc_if #(.DATA(DATA), .ADDR(ADDR), .LANE(LANE)) bus ();
        assign bus.a_en   = a_en;
        assign bus.a_we   = a_we;
        assign bus.a_addr = a_addr;
        assign bus.a_din  = a_din;
        assign bus.b_en   = b_en;
        assign bus.b_we   = b_we;
        assign bus.b_addr = b_addr;
        assign bus.b_din  = b_din;
        assign dut_dout[gi][0]  = bus.a_dout;
        assign dut_dout[gi][1]  = bus.b_dout;
        assign dut_valid[gi][0] = bus.a_valid;
        assign dut_valid[gi][1] = bus.b_valid;
        assign dut_busy[gi]     = bus.busy;
        assign dut_coll[gi]     = bus.collision;

        dp_ram_sc #(
            .DATA(DATA), .ADDR(ADDR), .LANE(LANE),
            .MODE((gi == 3) ? 0 : gi), .PIPE((gi == 3) ? 1 : 0),
            .CLEAR_VAL(CV)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [DEPTH];
    int          m_cnt  = 0;
    logic        m_busy = 1'b1;
    logic        m_coll = 1'b0;
    logic [15:0] m_s1_d [NCFG][2];
    logic        m_s1_v [NCFG][2];
    logic [15:0] m_out_d[NCFG][2];
    logic        m_out_v[NCFG][2];

    function automatic int mode_of(input int k);
        return (k == 3) ? 0 : k;
    endfunction

    function automatic bit pipe_of(input int k);
        return (k == 3);
    endfunction

    function automatic logic [15:0] lane_merge(input logic [15:0] o, input logic [15:0] d,
                                               input logic [1:0] we);
        logic [15:0] m;
        m = {{8{we[1]}}, {8{we[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    task automatic model_step();
        logic        en [2];
        logic [1:0]  we [2];
        logic [3:0]  ad [2];
        logic [15:0] din[2];
        logic        acc[2];
        logic [15:0] old[2];
        logic        rv;
        logic [15:0] rd;
        en[0] = a_en; we[0] = a_we; ad[0] = a_addr; din[0] = a_din;
        en[1] = b_en; we[1] = b_we; ad[1] = b_addr; din[1] = b_din;
        if (rst) begin
            m_cnt  = DEPTH + 1;
            m_busy = 1'b1;
            m_coll = 1'b0;
            for (int k = 0; k < NCFG; k++)
                for (int p = 0; p < 2; p++) begin
                    m_s1_d[k][p] = '0; m_s1_v[k][p] = 1'b0;
                    m_out_d[k][p] = '0; m_out_v[k][p] = 1'b0;
                end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            acc[p] = en[p] && !m_busy;
            old[p] = m_mem[ad[p]];
        end
        m_coll = acc[0] && acc[1] && (ad[0] == ad[1]) && (we[0] != 0 || we[1] != 0);
        for (int k = 0; k < NCFG; k++)
            for (int p = 0; p < 2; p++) begin
                rv = 1'b0;
                rd = m_s1_d[k][p];
                if (acc[p]) begin
                    if (we[p] == 0) begin rv = 1'b1; rd = old[p]; end
                    else if (mode_of(k) == 0) begin rv = 1'b1; rd = lane_merge(old[p], din[p], we[p]); end
                    else if (mode_of(k) == 1) begin rv = 1'b1; rd = old[p]; end
                end
                if (pipe_of(k)) begin
                    m_out_d[k][p] = m_s1_d[k][p];
                    m_out_v[k][p] = m_s1_v[k][p];
                end
                m_s1_d[k][p] = rd;
                m_s1_v[k][p] = rv;
                if (!pipe_of(k)) begin
                    m_out_d[k][p] = rd;
                    m_out_v[k][p] = rv;
                end
            end
        // A first, then B: B ends up owning lanes both ports write.
        for (int p = 0; p < 2; p++)
            if (acc[p]) m_mem[ad[p]] = lane_merge(m_mem[ad[p]], din[p], we[p]);
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0)
                for (int a = 0; a < DEPTH; a++) m_mem[a] = CV;
        end
        m_busy = (m_cnt != 0);
    endtask

    task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cfg%0d t=%0t got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every instance against the model away from the active edge.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            chk("busy", k, 16'(dut_busy[k]), 16'(m_busy));
            chk("collision", k, 16'(dut_coll[k]), 16'(m_coll));
            chk("a_valid", k, 16'(dut_valid[k][0]), 16'(m_out_v[k][0]));
            chk("b_valid", k, 16'(dut_valid[k][1]), 16'(m_out_v[k][1]));
            chk("a_dout", k, dut_dout[k][0], m_out_d[k][0]);
            chk("b_dout", k, dut_dout[k][1], m_out_d[k][1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic ae, input logic [1:0] awe, input logic [3:0] aa, input logic [15:0] ad,
                         input logic be, input logic [1:0] bwe, input logic [3:0] ba, input logic [15:0] bd);
        @(negedge clk);
        a_en = ae; a_we = awe; a_addr = aa; a_din = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_din = bd;
        $display("txn t=%0t A en=%b we=%b addr=%0d din=%h | B en=%b we=%b addr=%0d din=%h",
                 $time, ae, awe, aa, ad, be, bwe, ba, bd);
    endtask

    task automatic idle();
        drive(0, 2'b00, 4'd0, 16'h0, 0, 2'b00, 4'd0, 16'h0);
    endtask

    initial begin : stim
        int          n;
        logic [17:0] vbits;

        // Reset, partial clear, reset again mid-clear, then full clear.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut_busy[3]) n++;
            else break;
        end
        chk("busy_len", 3, 16'(n), 16'd16);

        // Back-to-back reads of the cleared memory; cfg3 has latency 2.
        for (int i = 0; i < 18; i++) begin
            vbits[i] = dut_valid[3][0];
            if (i >= 2) chk("stream_dout", 3, dut_dout[3][0], CV);
            a_en = (i < 16); a_we = 2'b00; a_addr = 4'(i);
            b_en = (i < 16); b_we = 2'b00; b_addr = 4'(15 - i);
            $display("txn t=%0t stream read A addr=%0d B addr=%0d", $time, i, 15 - i);
            @(negedge clk);
        end
        chk("stream_valid_lo", 3, 16'(vbits[15:0]), 16'hFFFC);
        chk("stream_valid_hi", 3, 16'(vbits[17:16]), 16'h0003);

        // Byte-lane writes.
        drive(1, 2'b11, 4'd3, 16'h1234, 0, 2'b00, 4'd0, 16'h0);
        drive(1, 2'b10, 4'd3, 16'hFF00, 0, 2'b00, 4'd0, 16'h0);
        drive(1, 2'b00, 4'd3, 16'h0000, 0, 2'b00, 4'd0, 16'h0);
        idle();
        chk("lane_rd", 0, dut_dout[0][0], 16'hFF34);
        chk("lane_rd_v", 0, 16'(dut_valid[0][0]), 16'h1);
        chk("model_mem3", 0, m_mem[3], 16'hFF34);

        // Same-port read-during-write per MODE.
        drive(1, 2'b11, 4'd5, 16'h0001, 0, 2'b00, 4'd0, 16'h0);
        idle();
        drive(1, 2'b01, 4'd5, 16'h00F0, 0, 2'b00, 4'd0, 16'h0);
        idle();
        chk("wf_dout", 0, dut_dout[0][0], 16'h00F0);
        chk("wf_valid", 0, 16'(dut_valid[0][0]), 16'h1);
        chk("rf_dout", 1, dut_dout[1][0], 16'h0001);
        chk("rf_valid", 1, 16'(dut_valid[1][0]), 16'h1);
        chk("nc_dout", 2, dut_dout[2][0], 16'hFF34);
        chk("nc_valid", 2, 16'(dut_valid[2][0]), 16'h0);

        // Write/write collision.
        drive(1, 2'b11, 4'd7, 16'hAAAA, 1, 2'b01, 4'd7, 16'h5555);
        idle();
        chk("ww_coll", 0, 16'(dut_coll[0]), 16'h1);
        drive(1, 2'b00, 4'd7, 16'h0000, 0, 2'b00, 4'd0, 16'h0);
        chk("ww_coll_end", 0, 16'(dut_coll[0]), 16'h0);
        idle();
        chk("ww_data", 0, dut_dout[0][0], 16'hAA55);

        // Read/write collision.
        drive(1, 2'b11, 4'd2, 16'h0000, 0, 2'b00, 4'd0, 16'h0);
        drive(1, 2'b00, 4'd2, 16'h0000, 1, 2'b11, 4'd2, 16'hBEEF);
        drive(1, 2'b00, 4'd2, 16'h0000, 0, 2'b00, 4'd0, 16'h0);
        chk("rw_old", 0, dut_dout[0][0], 16'h0000);
        chk("rw_coll", 0, 16'(dut_coll[0]), 16'h1);
        idle();
        chk("rw_new", 0, dut_dout[0][0], 16'hBEEF);
        chk("rw_coll_end", 0, 16'(dut_coll[0]), 16'h0);

        // Randomized traffic, with one reset pulse in the middle.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom),
                  4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3)),
                  16'($urandom));
            rst = (i == 150);
        end
        rst = 1'b0;
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
